// File: rtl/video_frame_crc.sv
// Per-frame CRC-32 signature and active-geometry checker for a pixel stream.
// One {r,g,b} word is folded into the CRC per clock; results publish on each frame close.
module video_frame_crc #(
   parameter int BPC_BOARD = 8,
   parameter int H_RES     = 672,
   parameter int V_RES     = 384,
   parameter int CNTW      = 16
) (
   input  logic                 clk_pix,
   input  logic                 rst_pix,
   input  logic                 frame,
   input  logic                 de,
   input  logic [BPC_BOARD-1:0] r,
   input  logic [BPC_BOARD-1:0] g,
   input  logic [BPC_BOARD-1:0] b,
   output logic [31:0]          crc,
   output logic                 crc_valid,
   output logic                 err_h,
   output logic                 err_v,
   output logic [CNTW-1:0]      frame_cnt
);

   localparam int              PW       = 3 * BPC_BOARD;
   localparam logic [31:0]     POLY     = 32'h04C11DB7;
   localparam logic [31:0]     CRC_INIT = 32'hFFFFFFFF;
   localparam logic [CNTW-1:0] H_EXP    = CNTW'(H_RES);
   localparam logic [CNTW-1:0] V_EXP    = CNTW'(V_RES);
   localparam logic [CNTW-1:0] CNT_MAX  = '1;

   typedef enum logic {S_SYNC, S_RUN} state_t;

   // MSB-first, non-reflected CRC-32 over a whole pixel word, unrolled into one cycle.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [PW-1:0] d);
      logic [31:0] x;
      logic        fb;
      x = c;
      for (int i = PW - 1; i >= 0; i--) begin
         fb = x[31] ^ d[i];
         x  = {x[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
      return x;
   endfunction

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (v == CNT_MAX) ? v : v + CNTW'(1);
   endfunction

   state_t          r_state, w_state_nxt;
   logic [31:0]     r_crc_acc, w_crc_acc_nxt;
   logic [CNTW-1:0] r_pix_cnt, w_pix_cnt_nxt;
   logic [CNTW-1:0] r_line_cnt, w_line_cnt_nxt;
   logic            r_herr, w_herr_nxt;
   logic            r_de_q, w_de_q_nxt;
   logic [31:0]     r_crc_out, w_crc_out_nxt;
   logic            r_valid, w_valid_nxt;
   logic            r_err_h, w_err_h_nxt;
   logic            r_err_v, w_err_v_nxt;
   logic [CNTW-1:0] r_frame_cnt, w_frame_cnt_nxt;

   logic [PW-1:0]   w_word;
   logic [31:0]     w_crc_base;
   logic [31:0]     w_crc_fold;
   logic            w_len_bad;
   logic [CNTW-1:0] w_lines_closed;

   // A frame pulse restarts the CRC, so a coincident pixel folds into the init value.
   assign w_word         = {r, g, b};
   assign w_crc_base     = frame ? CRC_INIT : r_crc_acc;
   assign w_crc_fold     = crc_step(w_crc_base, w_word);
   assign w_len_bad      = (r_pix_cnt != H_EXP);
   assign w_lines_closed = r_de_q ? sat_inc(r_line_cnt) : r_line_cnt;

   always_comb begin
      w_state_nxt     = r_state;
      w_crc_acc_nxt   = r_crc_acc;
      w_pix_cnt_nxt   = r_pix_cnt;
      w_line_cnt_nxt  = r_line_cnt;
      w_herr_nxt      = r_herr;
      w_de_q_nxt      = r_de_q;
      w_crc_out_nxt   = r_crc_out;
      w_valid_nxt     = 1'b0;
      w_err_h_nxt     = r_err_h;
      w_err_v_nxt     = r_err_v;
      w_frame_cnt_nxt = r_frame_cnt;

      case (r_state)
         S_SYNC: begin
            w_de_q_nxt = 1'b0;
            if (frame) begin
               w_state_nxt    = S_RUN;
               w_crc_acc_nxt  = de ? w_crc_fold : CRC_INIT;
               w_pix_cnt_nxt  = de ? CNTW'(1) : '0;
               w_line_cnt_nxt = '0;
               w_herr_nxt     = 1'b0;
               w_de_q_nxt     = de;
            end
         end
         S_RUN: begin
            if (frame) begin
               // Close: an open line is ended and length-checked before publishing.
               w_crc_out_nxt   = ~r_crc_acc;
               w_err_h_nxt     = r_herr | (r_de_q & w_len_bad);
               w_err_v_nxt     = (w_lines_closed != V_EXP);
               w_frame_cnt_nxt = r_frame_cnt + CNTW'(1);
               w_valid_nxt     = 1'b1;
               w_crc_acc_nxt   = de ? w_crc_fold : CRC_INIT;
               w_pix_cnt_nxt   = de ? CNTW'(1) : '0;
               w_line_cnt_nxt  = '0;
               w_herr_nxt      = 1'b0;
            end else if (de) begin
               w_crc_acc_nxt = w_crc_fold;
               w_pix_cnt_nxt = sat_inc(r_pix_cnt);
            end else if (r_de_q) begin
               w_herr_nxt     = r_herr | w_len_bad;
               w_pix_cnt_nxt  = '0;
               w_line_cnt_nxt = sat_inc(r_line_cnt);
            end
            w_de_q_nxt = de;
         end
         default: w_state_nxt = S_SYNC;
      endcase
   end

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         r_state     <= S_SYNC;
         r_crc_acc   <= CRC_INIT;
         r_pix_cnt   <= '0;
         r_line_cnt  <= '0;
         r_herr      <= 1'b0;
         r_de_q      <= 1'b0;
         r_crc_out   <= '0;
         r_valid     <= 1'b0;
         r_err_h     <= 1'b0;
         r_err_v     <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_crc_acc   <= w_crc_acc_nxt;
         r_pix_cnt   <= w_pix_cnt_nxt;
         r_line_cnt  <= w_line_cnt_nxt;
         r_herr      <= w_herr_nxt;
         r_de_q      <= w_de_q_nxt;
         r_crc_out   <= w_crc_out_nxt;
         r_valid     <= w_valid_nxt;
         r_err_h     <= w_err_h_nxt;
         r_err_v     <= w_err_v_nxt;
         r_frame_cnt <= w_frame_cnt_nxt;
      end
   end

   assign crc       = r_crc_out;
   assign crc_valid = r_valid;
   assign err_h     = r_err_h;
   assign err_v     = r_err_v;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_frame_crc.sv
// Directed bench for video_frame_crc on a reduced 8x4 geometry, with a
// transaction-level scoreboard predicting each published frame signature.
module tb_video_frame_crc;

   localparam int H = 8;
   localparam int V = 4;
   localparam logic [31:0] INIT = 32'hFFFFFFFF;

   typedef struct packed {
      logic [31:0] crc;
      logic        eh;
      logic        ev;
      logic [15:0] fc;
   } exp_t;

   logic        clk_pix = 1'b0;
   logic        rst_pix;
   logic        frame;
   logic        de;
   logic [7:0]  r, g, b;
   logic [31:0] crc;
   logic        crc_valid;
   logic        err_h, err_v;
   logic [15:0] frame_cnt;

   video_frame_crc #(.BPC_BOARD(8), .H_RES(H), .V_RES(V), .CNTW(16)) dut (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .frame(frame), .de(de),
      .r(r), .g(g), .b(b), .crc(crc), .crc_valid(crc_valid),
      .err_h(err_h), .err_v(err_v), .frame_cnt(frame_cnt)
   );

   always #5 clk_pix = ~clk_pix;

   exp_t        sb[$];
   logic [31:0] obs_crc[$];
   int          n_valid = 0;
   int          mon_checks = 0, mon_errors = 0;
   int          checks = 0, errors = 0;

   // Byte-wise software CRC-32 (poly 04C11DB7, MSB first), r byte first.
   function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [23:0] px);
      logic [31:0] x;
      logic [7:0]  byt;
      x = c;
      for (int k = 2; k >= 0; k--) begin
         byt = px[k*8 +: 8];
         x   = x ^ {byt, 24'h0};
         for (int j = 0; j < 8; j++) x = x[31] ? ((x << 1) ^ 32'h04C11DB7) : (x << 1);
      end
      return x;
   endfunction

   always @(negedge clk_pix) begin
      exp_t e;
      if (!rst_pix && crc_valid) begin
         n_valid++;
         obs_crc.push_back(crc);
         mon_checks++;
         if (sb.size() == 0) begin
            mon_errors++;
            $error("FAIL unexpected_valid crc=%h expected no pulse", crc);
         end else begin
            e = sb.pop_front();
            assert (crc === e.crc) else begin
               mon_errors++; $error("FAIL crc observed=%h expected=%h", crc, e.crc);
            end
            mon_checks++;
            assert (err_h === e.eh) else begin
               mon_errors++; $error("FAIL err_h observed=%b expected=%b", err_h, e.eh);
            end
            mon_checks++;
            assert (err_v === e.ev) else begin
               mon_errors++; $error("FAIL err_v observed=%b expected=%b", err_v, e.ev);
            end
            mon_checks++;
            assert (frame_cnt === e.fc) else begin
               mon_errors++; $error("FAIL frame_cnt observed=%0d expected=%0d", frame_cnt, e.fc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Transaction-level model state for the frame currently being sent.
   logic [31:0] m_crc;
   int          m_cur, m_lines;
   bit          m_herr, m_open, m_synced;
   logic [15:0] m_fcnt;

   task automatic cyc(input logic f, input logic d, input logic [23:0] px);
      frame = f; de = d; {r, g, b} = px;
      @(posedge clk_pix); #1;
   endtask

   task automatic pix_run(input int n, input logic [23:0] px);
      repeat (n) begin
         cyc(1'b0, 1'b1, px);
         if (m_synced) begin
            m_crc = crc_ref(m_crc, px); m_cur++; m_open = 1;
         end
      end
   endtask

   task automatic gap(input int n);
      repeat (n) cyc(1'b0, 1'b0, 24'h0);
      if (m_open) begin
         m_lines++;
         if (m_cur != H) m_herr = 1;
         m_cur = 0; m_open = 0;
      end
   endtask

   task automatic line(input int len, input logic [23:0] px);
      pix_run(len, px);
      gap(2);
   endtask

   task automatic fpulse(input logic d, input logic [23:0] px);
      exp_t e;
      if (m_synced) begin
         m_fcnt++;
         e.crc = ~m_crc;
         e.eh  = m_herr | (m_open && m_cur != H);
         e.ev  = ((m_lines + (m_open ? 1 : 0)) != V);
         e.fc  = m_fcnt;
         sb.push_back(e);
      end
      m_synced = 1; m_crc = INIT; m_lines = 0; m_cur = 0; m_herr = 0; m_open = 0;
      cyc(1'b1, d, px);
      if (d) begin
         m_crc = crc_ref(INIT, px); m_cur = 1; m_open = 1;
      end
   endtask

   task automatic body_good(input logic [23:0] px);
      repeat (V) line(H, px);
   endtask

   task automatic drain();
      frame = 0; de = 0;
      repeat (3) @(posedge clk_pix);
      #1;
      checks++;
      assert (sb.size() == 0) else begin
         errors++; $error("FAIL drain pending=%0d required=0", sb.size());
      end
   endtask

   task automatic chk_out_zero(input string tag);
      checks++;
      assert (crc === 32'h0) else begin errors++; $error("FAIL %s_crc observed=%h expected=0", tag, crc); end
      checks++;
      assert (crc_valid === 1'b0) else begin errors++; $error("FAIL %s_valid observed=%b expected=0", tag, crc_valid); end
      checks++;
      assert (err_h === 1'b0) else begin errors++; $error("FAIL %s_err_h observed=%b expected=0", tag, err_h); end
      checks++;
      assert (err_v === 1'b0) else begin errors++; $error("FAIL %s_err_v observed=%b expected=0", tag, err_v); end
      checks++;
      assert (frame_cnt === 16'h0) else begin errors++; $error("FAIL %s_fcnt observed=%0d expected=0", tag, frame_cnt); end
   endtask

   initial begin
      int          base, ia;
      logic [23:0] pc;
      pc = 24'h123456;
      m_synced = 0; m_fcnt = 0; m_open = 0; m_cur = 0; m_lines = 0; m_herr = 0; m_crc = INIT;
      rst_pix = 1; frame = 0; de = 0; {r, g, b} = 24'h0;
      repeat (3) @(posedge clk_pix);
      #1;
      chk_out_zero("reset");
      rst_pix = 0;

      // Pixels before the first frame pulse are ignored; three clean frames follow.
      pix_run(5, 24'hABCDEF);
      gap(2);
      fpulse(0, 0);
      body_good(pc);
      checks++;
      assert (n_valid == 0) else begin errors++; $error("FAIL presync_valid observed=%0d expected=0", n_valid); end
      fpulse(0, 0); body_good(pc);
      fpulse(0, 0); body_good(pc);
      fpulse(0, 0);
      drain();
      checks++;
      assert (n_valid == 3) else begin errors++; $error("FAIL sync_pulses observed=%0d expected=3", n_valid); end
      checks++;
      assert (obs_crc.size() >= 3 && obs_crc[0] === obs_crc[1] && obs_crc[1] === obs_crc[2]) else begin
         errors++; $error("FAIL same_crc observed=%0d entries first=%h required all equal", obs_crc.size(), crc);
      end

      // Empty frame, then back-to-back pulses on consecutive cycles.
      gap(3);
      fpulse(0, 0);
      fpulse(0, 0);
      drain();
      checks++;
      assert (n_valid == 5) else begin errors++; $error("FAIL b2b_pulses observed=%0d expected=5", n_valid); end
      checks++;
      assert (crc === 32'h0 && err_v === 1'b1 && err_h === 1'b0) else begin
         errors++; $error("FAIL empty_frame observed=%h/%b/%b expected=00000000/1/0", crc, err_v, err_h);
      end

      // Sensitivity: zero frame A, one-bit-different B, A again.
      base = obs_crc.size();
      fpulse(0, 0); body_good(24'h0);
      fpulse(0, 0);
      repeat (V - 1) line(H, 24'h0);
      pix_run(3, 24'h0); pix_run(1, 24'h010000); pix_run(4, 24'h0); gap(2);
      fpulse(0, 0); body_good(24'h0);
      fpulse(0, 0);
      // Single zero pixel frame against the software reference.
      pix_run(1, 24'h0); gap(1);
      fpulse(0, 0);
      drain();
      ia = base + 1;
      checks++;
      assert (obs_crc.size() >= base + 4 && obs_crc[ia] !== obs_crc[ia+1]) else begin
         errors++; $error("FAIL sens_differ A=%h B=%h required different", obs_crc[ia], obs_crc[ia+1]);
      end
      checks++;
      assert (obs_crc.size() >= base + 4 && obs_crc[ia+2] === obs_crc[ia]) else begin
         errors++; $error("FAIL sens_repeat observed=%h required=%h", obs_crc[ia+2], obs_crc[ia]);
      end
      checks++;
      assert (crc === ~crc_ref(INIT, 24'h0)) else begin
         errors++; $error("FAIL single_pixel observed=%h required=%h", crc, ~crc_ref(INIT, 24'h0));
      end

      // Geometry: short line, extra line, then a clean frame.
      line(H, pc); line(H - 1, pc); line(H, pc); line(H, pc);
      fpulse(0, 0);
      repeat (V + 1) line(H, pc);
      fpulse(0, 0); body_good(pc);
      fpulse(0, 0);
      drain();
      checks++;
      assert (err_h === 1'b0 && err_v === 1'b0) else begin
         errors++; $error("FAIL geom_recover observed=%b/%b expected=0/0", err_h, err_v);
      end

      // Frame pulse while a line is active: the coincident pixel opens the next frame.
      repeat (V - 1) line(H, pc);
      pix_run(3, pc);
      fpulse(1, pc);
      pix_run(H - 1, pc); gap(2);
      repeat (V - 1) line(H, pc);
      fpulse(0, 0);
      drain();
      checks++;
      assert (crc === obs_crc[0]) else begin
         errors++; $error("FAIL midline_crc observed=%h required=%h", crc, obs_crc[0]);
      end

      // Asynchronous reset halfway through a frame.
      line(H, pc); line(H, pc);
      rst_pix = 1;
      #1;
      chk_out_zero("async_rst");
      @(posedge clk_pix); #1;
      rst_pix = 0;
      m_synced = 0; m_fcnt = 0; m_open = 0; m_cur = 0; m_lines = 0; m_herr = 0;
      fpulse(0, 0); body_good(pc);
      fpulse(0, 0);
      drain();
      checks++;
      assert (frame_cnt === 16'd1 && crc === obs_crc[0]) else begin
         errors++; $error("FAIL post_rst observed=%0d/%h required=1/%h", frame_cnt, crc, obs_crc[0]);
      end

      $display("Result: errors=%0d of %0d checks", errors + mon_errors, checks + mon_checks);
      $finish;
   end

endmodule
